// File: rtl/sb_rx_msg_decoder.sv
// Sideband RX decoder: captures 64-bit packets into a FIFO, checks parity, and routes them
// either to an RDI message pulse or to the adapter as credit-controlled CFG_W-wide beats.
module sb_rx_msg_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CFG_W      = 32,
    parameter int CRD_MAX    = 4,
    parameter int DATA_TMO   = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_deser_done,
    input  logic [63:0]      i_deser_data,
    output logic             o_deser_done_sampled,
    output logic [CFG_W-1:0] o_pl_cfg,
    output logic             o_pl_cfg_vld,
    input  logic             i_pl_cfg_crd,
    input  logic             i_adapter_is_waked_up,
    output logic             o_wake_adapter,
    output logic             o_msg_valid,
    output logic [3:0]       o_msg_no,
    output logic             o_pl_nerror,
    output logic [2:0]       o_err_code
);

    localparam int NB = 64 / CFG_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(DATA_TMO + 1);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]    CRD_INIT = 4'(CRD_MAX);
    localparam logic [TW-1:0] TMO_CNT  = TW'(DATA_TMO);
    localparam logic [KW-1:0] LAST_IDX = KW'(NB - 1);

    localparam logic [4:0] OP_NODATA = 5'b10010;
    localparam logic [4:0] OP_DATA   = 5'b11011;
    localparam logic [2:0] DST_RDI   = 3'b110;
    localparam logic [2:0] DST_ADP   = 3'b001;

    localparam logic [2:0] ERR_PAR = 3'd1;
    localparam logic [2:0] ERR_DST = 3'd2;
    localparam logic [2:0] ERR_OPC = 3'd3;
    localparam logic [2:0] ERR_TMO = 3'd4;
    localparam logic [2:0] ERR_OVF = 3'd5;

    typedef enum logic [3:0] {
        IDLE, POP, DECODE, RDI_OUT, WAKE, DATA_WAIT, CFG_HDR, CFG_DATA, ERR
    } state_t;

    state_t            state;
    logic              done_q;
    logic              rise;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [63:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [63:0]       hdr;
    logic [63:0]       dat;
    logic              with_data;
    logic [KW-1:0]     beat_idx;
    logic [TW-1:0]     timer;
    logic [3:0]        crd;
    logic              ovf_pend;
    logic              issue;
    logic [3:0]        rdi_no;
    logic [2:0]        err_now;
    logic [63:0]       cur_word;
    logic [CFG_W-1:0]  beat_word;

    logic [4:0] opcode;
    logic [7:0] msgcode;
    logic [7:0] subcode;
    logic [2:0] dstid;
    logic       cp_ok;

    assign opcode  = hdr[4:0];
    assign msgcode = hdr[21:14];
    assign subcode = hdr[39:32];
    assign dstid   = hdr[58:56];
    assign cp_ok   = (hdr[62] == ^hdr[61:0]);

    // Capture: one push per rising edge of the level-style done strobe
    assign rise    = i_deser_done & ~done_q;
    assign full    = (count == FULL_CNT);
    assign pop     = (state == POP) || ((state == DATA_WAIT) && (count != '0));
    assign push_ok = rise && (!full || pop);
    assign drop    = rise && full && !pop;
    assign o_deser_done_sampled = rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            done_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            done_q <= i_deser_done;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_deser_data;
    end

    always_comb begin
        rdi_no = 4'd0;
        case (msgcode)
            8'h01: case (subcode)
                8'h01: rdi_no = 4'd1;
                8'h04: rdi_no = 4'd2;
                8'h08: rdi_no = 4'd3;
                8'h09: rdi_no = 4'd4;
                8'h0A: rdi_no = 4'd5;
                8'h0B: rdi_no = 4'd6;
                8'h0C: rdi_no = 4'd7;
                default: rdi_no = 4'd0;
            endcase
            8'h02: case (subcode)
                8'h01: rdi_no = 4'd8;
                8'h02: rdi_no = 4'd9;
                8'h04: rdi_no = 4'd10;
                8'h08: rdi_no = 4'd11;
                8'h09: rdi_no = 4'd12;
                8'h0A: rdi_no = 4'd13;
                8'h0B: rdi_no = 4'd14;
                8'h0C: rdi_no = 4'd15;
                default: rdi_no = 4'd0;
            endcase
            default: rdi_no = 4'd0;
        endcase
    end

    // Errors detected by the FSM this cycle; zero means none
    always_comb begin
        err_now = 3'd0;
        case (state)
            DECODE: begin
                if (!cp_ok)
                    err_now = ERR_PAR;
                else if (dstid == DST_RDI) begin
                    if (opcode != OP_NODATA || rdi_no == 4'd0) err_now = ERR_OPC;
                end else if (dstid == DST_ADP) begin
                    if (opcode != OP_NODATA && opcode != OP_DATA) err_now = ERR_OPC;
                end else
                    err_now = ERR_DST;
            end
            DATA_WAIT: begin
                if (count != '0) begin
                    if (hdr[63] != ^mem[rd_ptr]) err_now = ERR_PAR;
                end else if (timer == TMO_CNT)
                    err_now = ERR_TMO;
            end
            default: ;
        endcase
    end

    // A returned credit can be spent in the same cycle it arrives
    assign issue     = ((state == CFG_HDR) || (state == CFG_DATA)) && ((crd != 4'd0) || i_pl_cfg_crd);
    assign cur_word  = (state == CFG_DATA) ? dat : hdr;
    assign beat_word = cur_word[int'(beat_idx)*CFG_W +: CFG_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            hdr            <= '0;
            dat            <= '0;
            with_data      <= 1'b0;
            beat_idx       <= '0;
            timer          <= '0;
            crd            <= CRD_INIT;
            ovf_pend       <= 1'b0;
            o_pl_cfg       <= '0;
            o_pl_cfg_vld   <= 1'b0;
            o_wake_adapter <= 1'b0;
            o_msg_valid    <= 1'b0;
            o_msg_no       <= '0;
            o_pl_nerror    <= 1'b0;
            o_err_code     <= '0;
        end else begin
            o_pl_nerror  <= 1'b0;
            o_err_code   <= '0;
            o_pl_cfg_vld <= 1'b0;

            if (issue && !i_pl_cfg_crd)
                crd <= crd - 1'b1;
            else if (!issue && i_pl_cfg_crd && crd != CRD_INIT)
                crd <= crd + 1'b1;

            if (ovf_pend || drop) begin
                o_pl_nerror <= 1'b1;
                o_err_code  <= ERR_OVF;
                ovf_pend    <= ovf_pend && drop;
            end

            // An FSM error wins the output slot; overflow waits one cycle
            if (err_now != 3'd0) begin
                state       <= ERR;
                o_pl_nerror <= 1'b1;
                o_err_code  <= err_now;
                ovf_pend    <= ovf_pend || drop;
            end else begin
                case (state)
                    IDLE:
                        if (count != '0 || push_ok) state <= POP;
                    POP: begin
                        hdr   <= mem[rd_ptr];
                        state <= DECODE;
                    end
                    DECODE: begin
                        beat_idx <= '0;
                        timer    <= '0;
                        if (dstid == DST_RDI) begin
                            o_msg_valid <= 1'b1;
                            o_msg_no    <= rdi_no;
                            state       <= RDI_OUT;
                        end else begin
                            with_data <= (opcode == OP_DATA);
                            if (!i_adapter_is_waked_up) begin
                                o_wake_adapter <= 1'b1;
                                state          <= WAKE;
                            end else
                                state <= (opcode == OP_DATA) ? DATA_WAIT : CFG_HDR;
                        end
                    end
                    RDI_OUT: begin
                        o_msg_valid <= 1'b0;
                        o_msg_no    <= '0;
                        state       <= IDLE;
                    end
                    WAKE:
                        if (i_adapter_is_waked_up) begin
                            o_wake_adapter <= 1'b0;
                            state          <= with_data ? DATA_WAIT : CFG_HDR;
                        end
                    DATA_WAIT:
                        if (count != '0) begin
                            dat   <= mem[rd_ptr];
                            state <= CFG_HDR;
                        end else
                            timer <= timer + 1'b1;
                    CFG_HDR, CFG_DATA:
                        if (issue) begin
                            o_pl_cfg_vld <= 1'b1;
                            o_pl_cfg     <= beat_word;
                            if (beat_idx == LAST_IDX) begin
                                beat_idx <= '0;
                                state    <= (state == CFG_HDR && with_data) ? CFG_DATA : IDLE;
                            end else
                                beat_idx <= beat_idx + 1'b1;
                        end
                    ERR:
                        state <= IDLE;
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end

endmodule
